hazard_forwarding_unit: RTL and testbench
=========================================

# hazard_forwarding_unit

Parametrised hazard-detection and forwarding controller for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB). It drives the `hazard` stall/bubble line and the EX-stage operand forwarding selects, plus ID-stage forwarding for branches resolved in ID. It adds a multi-cycle data-memory wait state machine and saturating stall performance counters.

## Interface
- `REG_ADDR_W`, 5, register address width.
- `MEM_LATENCY`, 1, cycles a data-memory access occupies MEM (≥1).
- `COUNT_W`, 16, performance counter width.
- `ENABLE_ID_FWD`, 1, 1 = ID-stage branch-operand forwarding and branch hazards enabled; 0 = `forwardIdRs`/`forwardIdRt` held 00 and branch rules disabled.

Ports:
- `clk` in 1, single clock, rising edge.
- `reset` in 1, synchronous, active-low.
- `addressRsId`, `addressRtId` in REG_ADDR_W, source registers in ID.
- `usesRtId` in 1, ID instruction reads Rt.
- `branchId` in 1, ID instruction compares operands in ID.
- `addressRsEx`, `addressRtEx` in REG_ADDR_W, source registers in EX.
- `regWriteEx`, `memReadEx` in 1, EX control.
- `regWriteRegisterEx` in REG_ADDR_W, EX destination.
- `regWriteMem`, `memReadMem`, `memWriteMem` in 1, MEM control.
- `regWriteRegisterMem` in REG_ADDR_W, MEM destination.
- `regWriteWb` in 1, `writeRegisterWb` in REG_ADDR_W, WB write port.
- `hazard` out 1, freeze PC and IF/ID; load a bubble into ID/EX.
- `memStall` out 1, freeze every pipeline register (PC through MEM/WB).
- `forwardingMux0Ex`, `forwardingMux1Ex` out 2, Rs/Rt select in EX: 00 register file, 01 WB data, 10 MEM ALU result.
- `forwardIdRs`, `forwardIdRt` out 2, ID compare select: 00 register file, 01 MEM ALU result, 10 WB data.
- `stallCycles` out COUNT_W, count of cycles with `hazard`=1.
- `memWaitCycles` out COUNT_W, count of cycles with `memStall`=1.

## Operation
- A register match requires the destination to be nonzero. Register 0 never causes a hazard or a forward.
- Load-use: `memReadEx` and `regWriteRegisterEx` matches `addressRsId`, or matches `addressRtId` with `usesRtId` -> `hazard`.
- Branch hazards, active only when ENABLE_ID_FWD=1:
  - `branchId` and `regWriteEx` with a matching destination -> `hazard`.
  - `branchId` and `memReadMem` with a matching destination -> `hazard`.
- EX forwarding, applied per operand (Rs -> Mux0, Rt -> Mux1):
  - MEM match with `regWriteMem` and not `memReadMem` -> 10.
  - Otherwise WB match with `regWriteWb` -> 01.
  - Otherwise 00.
  - MEM has priority over WB.
- ID forwarding: MEM match with `regWriteMem` and not `memReadMem` -> 01; otherwise WB match -> 10; otherwise 00.
- Memory-wait FSM, states IDLE and WAIT, with internal counter `waitCnt`:
  - IDLE: `memStall` = (`memReadMem` or `memWriteMem`) and MEM_LATENCY>1. When it asserts, go to WAIT with `waitCnt`=1.
  - WAIT: `memStall` = (`waitCnt` < MEM_LATENCY-1). Each stalled cycle increments `waitCnt`. When `memStall` deasserts, return to IDLE with `waitCnt`=0.
  - Result: an access holds MEM for exactly MEM_LATENCY cycles.
  - With MEM_LATENCY=1 the FSM never leaves IDLE.
- While `memStall`=1, `hazard` is forced 0. The whole pipeline is frozen, so no bubble is inserted. Forwarding outputs stay valid.
- Counters saturate at all-ones and do not wrap.

## Timing
- `hazard`, `memStall` and all forward selects are combinational from the current-cycle inputs. Zero latency.
- FSM state, `waitCnt` and both counters update on the rising edge of `clk`.
- Reset (`reset`=0 at the edge):
  - FSM goes to IDLE, `waitCnt`=0, counters go to 0.
  - While `reset`=0, every output is forced to 0.
  - A reset taken in WAIT aborts the wait. After release the unit evaluates from IDLE.
- Load-use produces exactly 1 `hazard` cycle.
- Load followed by a dependent branch produces 2 consecutive cycles: the first from the EX rule, the second from the MEM-load rule.
- ALU result followed by a dependent branch produces 1 cycle.
- A hazard and a memory wait in the same cycle: the stall lasts the full wait, then `hazard` is re-evaluated once `memStall`=0.

## Test plan
- Load-use: `memReadEx`=1, `regWriteRegisterEx`=5, `addressRsId`=5 -> `hazard`=1 for 1 cycle, `stallCycles`=1. Same stimulus with destination 0 -> `hazard`=0.
- Double forward: MEM writes r3 (`regWriteMem`=1, `memReadMem`=0) and WB writes r3 with `addressRsEx`=`addressRtEx`=3 -> both EX selects=10. MEM writes r3 and WB writes r4 with Rt=4 -> Mux1=01.
- Branch after load: `branchId`=1, `addressRsId`=7, load to r7 in EX, then in MEM -> `hazard`=1 for 2 cycles, then `forwardIdRs`=10 when the load reaches WB.
- MEM_LATENCY=3, one load in MEM held constant -> `memStall`=1 for 2 cycles then 0, `memWaitCycles`=2, `hazard`=0 during the stall even with a matching load-use.
- Reset mid-WAIT (MEM_LATENCY=4, `reset`=0 on the 2nd stall cycle) -> all outputs 0, counters 0. After release with no access, `memStall`=0.
- COUNT_W=2, hold load-use for 5 cycles -> `stallCycles` saturates at 3.

Source files
------------

// File: rtl/hazard_forwarding_unit_if.sv
// hazard_forwarding_unit_if
// Pipeline-side bundle for the hazard/forwarding controller.
//   master : pipeline stages (drive register addresses and stage controls,
//            receive stall and forwarding selects)
//   slave  : hazard_forwarding_unit
// Signals:
//   addressRsId/addressRtId, usesRtId, branchId       ID-stage sources
//   addressRsEx/addressRtEx, regWriteEx, memReadEx,
//   regWriteRegisterEx                                EX-stage sources/dest
//   regWriteMem, memReadMem, memWriteMem,
//   regWriteRegisterMem                               MEM-stage controls/dest
//   regWriteWb, writeRegisterWb                       WB write port
//   hazard, memStall                                  stall controls
//   forwardingMux0Ex/1Ex, forwardIdRs/Rt              operand selects
//   stallCycles, memWaitCycles                        saturating counters
interface hazard_forwarding_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int COUNT_W    = 16
);
  logic [REG_ADDR_W-1:0] addressRsId;
  logic [REG_ADDR_W-1:0] addressRtId;
  logic                  usesRtId;
  logic                  branchId;
  logic [REG_ADDR_W-1:0] addressRsEx;
  logic [REG_ADDR_W-1:0] addressRtEx;
  logic                  regWriteEx;
  logic                  memReadEx;
  logic [REG_ADDR_W-1:0] regWriteRegisterEx;
  logic                  regWriteMem;
  logic                  memReadMem;
  logic                  memWriteMem;
  logic [REG_ADDR_W-1:0] regWriteRegisterMem;
  logic                  regWriteWb;
  logic [REG_ADDR_W-1:0] writeRegisterWb;
  logic                  hazard;
  logic                  memStall;
  logic [1:0]            forwardingMux0Ex;
  logic [1:0]            forwardingMux1Ex;
  logic [1:0]            forwardIdRs;
  logic [1:0]            forwardIdRt;
  logic [COUNT_W-1:0]    stallCycles;
  logic [COUNT_W-1:0]    memWaitCycles;

  modport master (
    output addressRsId, addressRtId, usesRtId, branchId,
           addressRsEx, addressRtEx, regWriteEx, memReadEx, regWriteRegisterEx,
           regWriteMem, memReadMem, memWriteMem, regWriteRegisterMem,
           regWriteWb, writeRegisterWb,
    input  hazard, memStall, forwardingMux0Ex, forwardingMux1Ex,
           forwardIdRs, forwardIdRt, stallCycles, memWaitCycles
  );

  modport slave (
    input  addressRsId, addressRtId, usesRtId, branchId,
           addressRsEx, addressRtEx, regWriteEx, memReadEx, regWriteRegisterEx,
           regWriteMem, memReadMem, memWriteMem, regWriteRegisterMem,
           regWriteWb, writeRegisterWb,
    output hazard, memStall, forwardingMux0Ex, forwardingMux1Ex,
           forwardIdRs, forwardIdRt, stallCycles, memWaitCycles
  );
endinterface

// File: rtl/hazard_forwarding_unit.sv
// hazard_forwarding_unit
// Hazard detection and operand forwarding for a 5-stage MIPS pipeline, with
// a multi-cycle data-memory wait FSM and saturating stall counters.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low; forces every output to 0 while low
//   bus   : hazard_forwarding_unit_if.slave (stage controls in; hazard,
//           memStall, forward selects and counters out)
// hazard/memStall/forward selects are combinational from current inputs;
// FSM state, wait counter and performance counters are registered.
module hazard_forwarding_unit #(
  parameter int REG_ADDR_W    = 5,
  parameter int MEM_LATENCY   = 1,
  parameter int COUNT_W       = 16,
  parameter int ENABLE_ID_FWD = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  hazard_forwarding_unit_if.slave  bus
);

  localparam int WAIT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) + 1 : 1;
  // waitCnt value at which the final (unstalled) MEM cycle is reached
  localparam logic [WAIT_W-1:0]  LAST_STALL = WAIT_W'(MEM_LATENCY - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX  = {COUNT_W{1'b1}};

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} memStateT;

  memStateT            stateR, stateNextS;
  logic [WAIT_W-1:0]   waitCntR, waitCntNextS;
  logic [COUNT_W-1:0]  stallCyclesR, memWaitCyclesR;
  logic                memStallS, hazardS, loadUseS, branchHazS;
  logic                memFwdOkS;
  logic [1:0]          fwdMux0S, fwdMux1S, fwdIdRsS, fwdIdRtS;

  // Register 0 is hard-wired, so a zero destination never matches
  function automatic logic regHit(input logic [REG_ADDR_W-1:0] dest,
                                  input logic [REG_ADDR_W-1:0] src);
    return (dest != '0) && (dest == src);
  endfunction

  // Does the ID instruction read the given destination register
  function automatic logic idReads(input logic [REG_ADDR_W-1:0] dest,
                                   input logic [REG_ADDR_W-1:0] rs,
                                   input logic [REG_ADDR_W-1:0] rt,
                                   input logic                  usesRt);
    return regHit(dest, rs) || (usesRt && regHit(dest, rt));
  endfunction

  // Hazard detection: load-use plus branch-in-ID rules, suppressed under memStall
  always_comb begin
    loadUseS   = bus.memReadEx && idReads(bus.regWriteRegisterEx, bus.addressRsId,
                                          bus.addressRtId, bus.usesRtId);
    branchHazS = 1'b0;
    if (ENABLE_ID_FWD != 0) begin
      branchHazS = bus.branchId &&
                   ((bus.regWriteEx && idReads(bus.regWriteRegisterEx, bus.addressRsId,
                                               bus.addressRtId, bus.usesRtId)) ||
                    (bus.memReadMem && idReads(bus.regWriteRegisterMem, bus.addressRsId,
                                               bus.addressRtId, bus.usesRtId)));
    end else begin
      branchHazS = 1'b0;
    end
    // A frozen pipeline must not take a bubble; re-evaluated once the wait ends
    hazardS = !memStallS && (loadUseS || branchHazS);
  end

  // Forwarding selects; a MEM-stage load has no ALU result to forward
  always_comb begin
    memFwdOkS = bus.regWriteMem && !bus.memReadMem;
    fwdMux0S  = 2'b00;
    fwdMux1S  = 2'b00;
    fwdIdRsS  = 2'b00;
    fwdIdRtS  = 2'b00;
    if (memFwdOkS && regHit(bus.regWriteRegisterMem, bus.addressRsEx)) fwdMux0S = 2'b10;
    else if (bus.regWriteWb && regHit(bus.writeRegisterWb, bus.addressRsEx)) fwdMux0S = 2'b01;
    else fwdMux0S = 2'b00;
    if (memFwdOkS && regHit(bus.regWriteRegisterMem, bus.addressRtEx)) fwdMux1S = 2'b10;
    else if (bus.regWriteWb && regHit(bus.writeRegisterWb, bus.addressRtEx)) fwdMux1S = 2'b01;
    else fwdMux1S = 2'b00;
    // ID-stage encoding differs from EX: 01 = MEM result, 10 = WB data
    if (ENABLE_ID_FWD != 0) begin
      if (memFwdOkS && regHit(bus.regWriteRegisterMem, bus.addressRsId)) fwdIdRsS = 2'b01;
      else if (bus.regWriteWb && regHit(bus.writeRegisterWb, bus.addressRsId)) fwdIdRsS = 2'b10;
      else fwdIdRsS = 2'b00;
      if (memFwdOkS && regHit(bus.regWriteRegisterMem, bus.addressRtId)) fwdIdRtS = 2'b01;
      else if (bus.regWriteWb && regHit(bus.writeRegisterWb, bus.addressRtId)) fwdIdRtS = 2'b10;
      else fwdIdRtS = 2'b00;
    end else begin
      fwdIdRsS = 2'b00;
      fwdIdRtS = 2'b00;
    end
  end

  // Memory-wait FSM next state: an access occupies MEM for MEM_LATENCY cycles
  always_comb begin
    stateNextS   = stateR;
    waitCntNextS = waitCntR;
    memStallS    = 1'b0;
    case (stateR)
      IDLE: begin
        memStallS = (bus.memReadMem || bus.memWriteMem) && (MEM_LATENCY > 1);
        if (memStallS) begin
          stateNextS   = WAIT;
          waitCntNextS = WAIT_W'(1);
        end else begin
          stateNextS   = IDLE;
          waitCntNextS = '0;
        end
      end
      WAIT: begin
        memStallS = (waitCntR < LAST_STALL);
        if (memStallS) begin
          stateNextS   = WAIT;
          waitCntNextS = waitCntR + WAIT_W'(1);
        end else begin
          stateNextS   = IDLE;
          waitCntNextS = '0;
        end
      end
      default: begin
        stateNextS   = IDLE;
        waitCntNextS = '0;
        memStallS    = 1'b0;
      end
    endcase
  end

  // FSM state, wait counter and saturating performance counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      stateR         <= IDLE;
      waitCntR       <= '0;
      stallCyclesR   <= '0;
      memWaitCyclesR <= '0;
    end else begin
      stateR   <= stateNextS;
      waitCntR <= waitCntNextS;
      if (hazardS && (stallCyclesR != COUNT_MAX)) begin
        stallCyclesR <= stallCyclesR + COUNT_W'(1);
      end
      if (memStallS && (memWaitCyclesR != COUNT_MAX)) begin
        memWaitCyclesR <= memWaitCyclesR + COUNT_W'(1);
      end
    end
  end

  // Outputs are all held at 0 while reset is low
  assign bus.hazard           = reset & hazardS;
  assign bus.memStall         = reset & memStallS;
  assign bus.forwardingMux0Ex = reset ? fwdMux0S : 2'b00;
  assign bus.forwardingMux1Ex = reset ? fwdMux1S : 2'b00;
  assign bus.forwardIdRs      = reset ? fwdIdRsS : 2'b00;
  assign bus.forwardIdRt      = reset ? fwdIdRtS : 2'b00;
  assign bus.stallCycles      = reset ? stallCyclesR   : '0;
  assign bus.memWaitCycles    = reset ? memWaitCyclesR : '0;

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Self-checking bench for hazard_forwarding_unit. Three configurations run on
// the same stimulus:
//   dut0: MEM_LATENCY=1, COUNT_W=16, ENABLE_ID_FWD=1
//   dut1: MEM_LATENCY=3, COUNT_W=2,  ENABLE_ID_FWD=1
//   dut2: MEM_LATENCY=4, COUNT_W=16, ENABLE_ID_FWD=0
// A reference model pushes expected outputs into per-DUT queues; a negedge
// monitor pops and compares.
module tb_hazard_forwarding_unit;
  localparam int NDUT = 3;

  typedef struct packed {
    logic [4:0] rsId, rtId;
    logic       usesRtId, branchId;
    logic [4:0] rsEx, rtEx;
    logic       regWriteEx, memReadEx;
    logic [4:0] dEx;
    logic       regWriteMem, memReadMem, memWriteMem;
    logic [4:0] dMem;
    logic       regWriteWb;
    logic [4:0] dWb;
  } stimT;

  typedef struct packed {
    logic        hazard, memStall;
    logic [1:0]  fm0, fm1, fidRs, fidRt;
    logic [15:0] stallCnt, waitCnt;
  } expT;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  stimT stim  = '0;
  int   checks = 0;
  int   fails  = 0;

  expT  expQ[NDUT][$];
  int   remaining[NDUT];
  int   mStall[NDUT];
  int   mWait[NDUT];

  always #5 clk = ~clk;

  hazard_forwarding_unit_if #(.REG_ADDR_W(5), .COUNT_W(16)) bus0 ();
  hazard_forwarding_unit_if #(.REG_ADDR_W(5), .COUNT_W(2))  bus1 ();
  hazard_forwarding_unit_if #(.REG_ADDR_W(5), .COUNT_W(16)) bus2 ();

  hazard_forwarding_unit #(.REG_ADDR_W(5), .MEM_LATENCY(1), .COUNT_W(16), .ENABLE_ID_FWD(1))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  hazard_forwarding_unit #(.REG_ADDR_W(5), .MEM_LATENCY(3), .COUNT_W(2), .ENABLE_ID_FWD(1))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));
  hazard_forwarding_unit #(.REG_ADDR_W(5), .MEM_LATENCY(4), .COUNT_W(16), .ENABLE_ID_FWD(0))
    dut2 (.clk(clk), .reset(reset), .bus(bus2));

  always_comb begin
    bus0.addressRsId = stim.rsId;  bus0.addressRtId = stim.rtId;
    bus0.usesRtId = stim.usesRtId; bus0.branchId = stim.branchId;
    bus0.addressRsEx = stim.rsEx;  bus0.addressRtEx = stim.rtEx;
    bus0.regWriteEx = stim.regWriteEx; bus0.memReadEx = stim.memReadEx;
    bus0.regWriteRegisterEx = stim.dEx;
    bus0.regWriteMem = stim.regWriteMem; bus0.memReadMem = stim.memReadMem;
    bus0.memWriteMem = stim.memWriteMem; bus0.regWriteRegisterMem = stim.dMem;
    bus0.regWriteWb = stim.regWriteWb; bus0.writeRegisterWb = stim.dWb;
  end

  always_comb begin
    bus1.addressRsId = stim.rsId;  bus1.addressRtId = stim.rtId;
    bus1.usesRtId = stim.usesRtId; bus1.branchId = stim.branchId;
    bus1.addressRsEx = stim.rsEx;  bus1.addressRtEx = stim.rtEx;
    bus1.regWriteEx = stim.regWriteEx; bus1.memReadEx = stim.memReadEx;
    bus1.regWriteRegisterEx = stim.dEx;
    bus1.regWriteMem = stim.regWriteMem; bus1.memReadMem = stim.memReadMem;
    bus1.memWriteMem = stim.memWriteMem; bus1.regWriteRegisterMem = stim.dMem;
    bus1.regWriteWb = stim.regWriteWb; bus1.writeRegisterWb = stim.dWb;
  end

  always_comb begin
    bus2.addressRsId = stim.rsId;  bus2.addressRtId = stim.rtId;
    bus2.usesRtId = stim.usesRtId; bus2.branchId = stim.branchId;
    bus2.addressRsEx = stim.rsEx;  bus2.addressRtEx = stim.rtEx;
    bus2.regWriteEx = stim.regWriteEx; bus2.memReadEx = stim.memReadEx;
    bus2.regWriteRegisterEx = stim.dEx;
    bus2.regWriteMem = stim.regWriteMem; bus2.memReadMem = stim.memReadMem;
    bus2.memWriteMem = stim.memWriteMem; bus2.regWriteRegisterMem = stim.dMem;
    bus2.regWriteWb = stim.regWriteWb; bus2.writeRegisterWb = stim.dWb;
  end

  function automatic int latOf(input int d);
    case (d)
      0: return 1;
      1: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int cntMax(input int d);
    return (d == 1) ? 3 : 65535;
  endfunction

  function automatic logic hit(input logic [4:0] dest, input logic [4:0] src);
    return (dest != 5'd0) && (dest == src);
  endfunction

  function automatic logic reads(input stimT s, input logic [4:0] dest);
    return hit(dest, s.rsId) || (s.usesRtId && hit(dest, s.rtId));
  endfunction

  function automatic logic [1:0] exSel(input stimT s, input logic [4:0] src);
    if (s.regWriteMem && !s.memReadMem && hit(s.dMem, src)) return 2'd2;
    if (s.regWriteWb && hit(s.dWb, src)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [1:0] idSel(input stimT s, input logic [4:0] src, input bit en);
    if (!en) return 2'd0;
    if (s.regWriteMem && !s.memReadMem && hit(s.dMem, src)) return 2'd1;
    if (s.regWriteWb && hit(s.dWb, src)) return 2'd2;
    return 2'd0;
  endfunction

  // Reference model: remaining[] counts the cycles the current access still
  // occupies MEM; the last of them is not stalled.
  function automatic expT modelStep(input int d, input stimT s, input logic rstN);
    expT e;
    bit  idf, stall, loadUse, br;
    e   = '0;
    idf = (d != 2);
    if (!rstN) begin
      remaining[d] = 0;
      mStall[d]    = 0;
      mWait[d]     = 0;
      return e;
    end
    if (remaining[d] == 0 && (s.memReadMem || s.memWriteMem) && latOf(d) > 1)
      remaining[d] = latOf(d);
    stall   = remaining[d] > 1;
    loadUse = s.memReadEx && reads(s, s.dEx);
    br      = idf && s.branchId &&
              ((s.regWriteEx && reads(s, s.dEx)) || (s.memReadMem && reads(s, s.dMem)));
    e.hazard   = !stall && (loadUse || br);
    e.memStall = stall;
    e.fm0      = exSel(s, s.rsEx);
    e.fm1      = exSel(s, s.rtEx);
    e.fidRs    = idSel(s, s.rsId, idf);
    e.fidRt    = idSel(s, s.rtId, idf);
    e.stallCnt = 16'(mStall[d]);
    e.waitCnt  = 16'(mWait[d]);
    if (e.hazard && mStall[d] < cntMax(d)) mStall[d]++;
    if (stall && mWait[d] < cntMax(d)) mWait[d]++;
    if (remaining[d] > 0) remaining[d]--;
    return e;
  endfunction

  function automatic expT actOf(input int d);
    expT a;
    case (d)
      0: a = '{bus0.hazard, bus0.memStall, bus0.forwardingMux0Ex, bus0.forwardingMux1Ex,
               bus0.forwardIdRs, bus0.forwardIdRt, 16'(bus0.stallCycles), 16'(bus0.memWaitCycles)};
      1: a = '{bus1.hazard, bus1.memStall, bus1.forwardingMux0Ex, bus1.forwardingMux1Ex,
               bus1.forwardIdRs, bus1.forwardIdRt, 16'(bus1.stallCycles), 16'(bus1.memWaitCycles)};
      default: a = '{bus2.hazard, bus2.memStall, bus2.forwardingMux0Ex, bus2.forwardingMux1Ex,
               bus2.forwardIdRs, bus2.forwardIdRt, 16'(bus2.stallCycles), 16'(bus2.memWaitCycles)};
    endcase
    return a;
  endfunction

  // Monitor: compare every presented output set against the scoreboard
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (expQ[d].size() > 0) begin
        expT e;
        expT a;
        e = expQ[d].pop_front();
        a = actOf(d);
        checks++;
        if (a !== e) begin
          fails++;
          $display("FAIL dut%0d outputs at t=%0t: got %h expected %h (hz,ms,fm0,fm1,fidRs,fidRt,stall,wait)",
                   d, $time, a, e);
        end
      end
    end
  end

  task automatic step(input stimT s, input logic r);
    @(posedge clk);
    #1;
    stim  = s;
    reset = r;
    for (int d = 0; d < NDUT; d++) expQ[d].push_back(modelStep(d, s, r));
  endtask

  task automatic expectVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic stimT randStim();
    stimT s;
    s.rsId        = 5'($urandom_range(0, 3));
    s.rtId        = 5'($urandom_range(0, 3));
    s.usesRtId    = 1'($urandom_range(0, 1));
    s.branchId    = ($urandom_range(0, 3) == 0);
    s.rsEx        = 5'($urandom_range(0, 3));
    s.rtEx        = 5'($urandom_range(0, 3));
    s.regWriteEx  = 1'($urandom_range(0, 1));
    s.memReadEx   = ($urandom_range(0, 3) == 0);
    s.dEx         = 5'($urandom_range(0, 3));
    s.regWriteMem = 1'($urandom_range(0, 1));
    s.memReadMem  = ($urandom_range(0, 5) == 0);
    s.memWriteMem = ($urandom_range(0, 7) == 0);
    s.dMem        = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
    s.regWriteWb  = 1'($urandom_range(0, 1));
    s.dWb         = 5'($urandom_range(0, 3));
    return s;
  endfunction

  initial begin
    stimT z;
    stimT s;
    z = '0;
    step(z, 1'b0);
    step(z, 1'b0);
    step(z, 1'b1);

    // Load-use: one hazard cycle, counter follows; destination 0 never hazards
    s = z; s.memReadEx = 1'b1; s.regWriteEx = 1'b1; s.dEx = 5'd5; s.rsId = 5'd5;
    step(s, 1'b1);
    @(negedge clk); expectVal("loadUse hazard", int'(bus0.hazard), 1);
    step(z, 1'b1);
    @(negedge clk); expectVal("loadUse stallCycles", int'(bus0.stallCycles), 1);
    s.dEx = 5'd0; s.rsId = 5'd0;
    step(s, 1'b1);
    @(negedge clk); expectVal("r0 no hazard", int'(bus0.hazard), 0);

    // Double forward: MEM beats WB
    s = z; s.regWriteMem = 1'b1; s.dMem = 5'd3; s.regWriteWb = 1'b1; s.dWb = 5'd3;
    s.rsEx = 5'd3; s.rtEx = 5'd3;
    step(s, 1'b1);
    @(negedge clk);
    expectVal("dblfwd mux0", int'(bus0.forwardingMux0Ex), 2);
    expectVal("dblfwd mux1", int'(bus0.forwardingMux1Ex), 2);
    s.dWb = 5'd4; s.rtEx = 5'd4;
    step(s, 1'b1);
    @(negedge clk); expectVal("wbfwd mux1", int'(bus0.forwardingMux1Ex), 1);

    // Branch after load: two hazard cycles then WB forward into ID
    for (int i = 0; i < 5; i++) step(z, 1'b1);
    s = z; s.branchId = 1'b1; s.rsId = 5'd7; s.memReadEx = 1'b1; s.regWriteEx = 1'b1; s.dEx = 5'd7;
    step(s, 1'b1);
    @(negedge clk); expectVal("brload EX hazard", int'(bus0.hazard), 1);
    s = z; s.branchId = 1'b1; s.rsId = 5'd7; s.memReadMem = 1'b1; s.regWriteMem = 1'b1; s.dMem = 5'd7;
    step(s, 1'b1);
    @(negedge clk); expectVal("brload MEM hazard", int'(bus0.hazard), 1);
    s = z; s.branchId = 1'b1; s.rsId = 5'd7; s.regWriteWb = 1'b1; s.dWb = 5'd7;
    step(s, 1'b1);
    @(negedge clk);
    expectVal("brload WB fwdIdRs", int'(bus0.forwardIdRs), 2);
    expectVal("brload WB hazard", int'(bus0.hazard), 0);
    expectVal("idfwd disabled", int'(bus2.forwardIdRs), 0);

    // MEM_LATENCY=3 load held in MEM: two stall cycles, hazard masked meanwhile
    for (int i = 0; i < 6; i++) step(z, 1'b1);
    step(z, 1'b0);
    s = z; s.memReadMem = 1'b1; s.regWriteMem = 1'b1; s.dMem = 5'd9;
    s.memReadEx = 1'b1; s.regWriteEx = 1'b1; s.dEx = 5'd2; s.rsId = 5'd2;
    step(s, 1'b1);
    @(negedge clk);
    expectVal("lat3 stall1", int'(bus1.memStall), 1);
    expectVal("lat3 hazard masked", int'(bus1.hazard), 0);
    step(s, 1'b1);
    @(negedge clk); expectVal("lat3 stall2", int'(bus1.memStall), 1);
    step(s, 1'b1);
    @(negedge clk);
    expectVal("lat3 stall end", int'(bus1.memStall), 0);
    expectVal("lat3 hazard after", int'(bus1.hazard), 1);
    step(z, 1'b1);
    @(negedge clk); expectVal("lat3 memWaitCycles", int'(bus1.memWaitCycles), 2);

    // Reset in the middle of a MEM_LATENCY=4 wait
    for (int i = 0; i < 6; i++) step(z, 1'b1);
    s = z; s.memReadMem = 1'b1;
    step(s, 1'b1);
    @(negedge clk); expectVal("lat4 stall", int'(bus2.memStall), 1);
    step(s, 1'b0);
    @(negedge clk);
    expectVal("rst memStall", int'(bus2.memStall), 0);
    expectVal("rst memWaitCycles", int'(bus2.memWaitCycles), 0);
    step(z, 1'b1);
    @(negedge clk);
    expectVal("post-rst memStall", int'(bus2.memStall), 0);
    expectVal("post-rst memWaitCycles", int'(bus2.memWaitCycles), 0);

    // Counter saturation with COUNT_W=2
    step(z, 1'b0);
    s = z; s.memReadEx = 1'b1; s.regWriteEx = 1'b1; s.dEx = 5'd5; s.rsId = 5'd5;
    for (int i = 0; i < 5; i++) step(s, 1'b1);
    step(z, 1'b1);
    @(negedge clk);
    expectVal("sat stallCycles w2", int'(bus1.stallCycles), 3);
    expectVal("stallCycles w16", int'(bus0.stallCycles), 5);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 800; i++) step(randStim(), ($urandom_range(0, 63) != 0));

    step(z, 1'b1);
    step(z, 1'b1);
    @(negedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) expectVal("scoreboard drained", expQ[d].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
